// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types and saturation helper for the digit-serial adder/subtractor
package addsub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef struct packed {
        logic co;
        logic ovf;
        logic zero;
        logic neg;
    } flags_t;

    // sign 0 -> signed max (0111..), sign 1 -> signed min (1000..), right-aligned in 64 bits
    function automatic logic [63:0] sat_value(input logic sign, input int width);
        logic [63:0] m;
        m = 64'd1 << (width - 1);
        return sign ? m : m - 64'd1;
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// addsub_chunk: CHUNK-bit ripple adder slice with per-bit B inversion for subtract
module addsub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        logic bx;
        assign bx       = b[i] ^ sub;
        assign s[i]     = a[i] ^ bx ^ c[i];
        assign c[i + 1] = (a[i] & bx) | (c[i] & (a[i] ^ bx));
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK - 1];
endmodule

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial add/subtract with saturation and flags, one shared chunk adder
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam logic [63:0] SAT_MAX = sat_value(1'b0, WIDTH);
    localparam logic [63:0] SAT_MIN = sat_value(1'b1, WIDTH);

    if (WIDTH < 2 || WIDTH % CHUNK != 0) begin : g_bad_params
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_e           state;
    flags_t           flags;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt, s_fin;
    logic             sub_q, sat_q, sign_a, carry, c_out, c_msb, ovf_raw;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] sum_c;

    addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a    (a_sh[CHUNK-1:0]),
        .b    (b_sh[CHUNK-1:0]),
        .ci   (carry),
        .sub  (sub_q),
        .s    (sum_c),
        .co   (c_out),
        .c_msb(c_msb)
    );

    // operands shift down one chunk per cycle; the result fills in from the top
    always_comb begin
        res_nxt = res >> CHUNK;
        res_nxt[WIDTH-1 -: CHUNK] = sum_c;
        ovf_raw = c_msb ^ c_out;
        s_fin = (sat_q && ovf_raw) ? (sign_a ? SAT_MIN[WIDTH-1:0] : SAT_MAX[WIDTH-1:0]) : res_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sub_q  <= 1'b0;
            sat_q  <= 1'b0;
            sign_a <= 1'b0;
            carry  <= 1'b0;
            idx    <= '0;
            res    <= '0;
            s      <= '0;
            flags  <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    sub_q  <= sub;
                    sat_q  <= sat;
                    sign_a <= a[WIDTH-1];
                    carry  <= sub;
                    idx    <= '0;
                    state  <= RUN;
                end
                RUN: begin
                    a_sh  <= a_sh >> CHUNK;
                    b_sh  <= b_sh >> CHUNK;
                    carry <= c_out;
                    idx   <= idx + 1'b1;
                    res   <= res_nxt;
                    if (idx == LAST) begin
                        s     <= s_fin;
                        flags <= '{co: c_out, ovf: ovf_raw, zero: (s_fin == '0), neg: s_fin[WIDTH-1]};
                        state <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign co        = flags.co;
    assign ovf       = flags.ovf;
    assign zero      = flags.zero;
    assign neg       = flags.neg;
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed self-checking bench for addsub_serial at WIDTH=16, CHUNK=4
module tb_addsub_serial;
    logic        clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic        sub = 1'b0, sat = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, co, ovf, zero, neg;
    logic [15:0] s;
    int          total = 0, bad = 0;

    addsub_serial #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sat(sat), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .co(co), .ovf(ovf), .zero(zero), .neg(neg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // inputs are scrambled right after the accept edge to prove they were latched
    task automatic accept(input logic [15:0] ta, input logic [15:0] tb, input logic ts, input logic tsat);
        int n = 0;
        while (!in_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        a = ta; b = tb; sub = ts; sat = tsat; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ta; b = ~tb; sub = ~ts; sat = ~tsat;
    endtask

    // ef = {co, ovf, zero, neg}
    task automatic result(input logic [15:0] es, input logic [3:0] ef, input int stall);
        int   lat = 0;
        logic busy = 1'b0;
        out_ready = (stall == 0);
        while (!out_valid && lat < 20) begin
            if (in_ready) busy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd4);
        check("ready_in_run", 32'(busy), 32'd0);
        check("ready_in_done", 32'(in_ready), 32'd0);
        check("s", 32'(s), 32'(es));
        check("flags", 32'({co, ovf, zero, neg}), 32'(ef));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_s", 32'(s), 32'(es));
            check("stall_flags", 32'({co, ovf, zero, neg}), 32'(ef));
            check("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_flags", 32'({co, ovf, zero, neg}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        accept(16'h1234, 16'h0FFF, 1'b0, 1'b0); result(16'h2233, 4'b0000, 0);
        accept(16'h0005, 16'h0007, 1'b1, 1'b0); result(16'hFFFE, 4'b0001, 0);
        accept(16'h7FFF, 16'h0001, 1'b0, 1'b0); result(16'h8000, 4'b0101, 0);
        accept(16'h7FFF, 16'h0001, 1'b0, 1'b1); result(16'h7FFF, 4'b0100, 0);
        accept(16'h8000, 16'h0001, 1'b1, 1'b1); result(16'h8000, 4'b1101, 0);
        accept(16'h1234, 16'h1234, 1'b1, 1'b0); result(16'h0000, 4'b1010, 3);
        accept(16'hABCD, 16'h1111, 1'b1, 1'b0); result(16'h9ABC, 4'b1001, 0);

        accept(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_s", 32'(s), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_stale", 32'(out_valid), 32'd0);
        accept(16'h0001, 16'h0001, 1'b0, 1'b0); result(16'h0002, 4'b0000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
